mos_switch_pair: RTL and testbench



---
 rtl/mos_pkg.sv | 40 ++++
 rtl/mos_lane.sv | 26 ++
 rtl/mos_switch_pair.sv | 57 +++++
 tb/tb_mos_switch_pair.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mos_pkg.sv
// Shared 4-value encoding and switch-level device/resolution functions.
// Pure combinational helpers; no state, no flow control.
package mos_pkg;

    typedef logic [1:0] logic4_t;

    localparam logic4_t L0 = 2'b00;
    localparam logic4_t L1 = 2'b01;
    localparam logic4_t LZ = 2'b10;
    localparam logic4_t LX = 2'b11;

    // An undetermined gate may or may not conduct, so a floating source stays Z.
    function automatic logic4_t nmos_eval(input logic4_t gate, input logic4_t src);
        case (gate)
            L1:      return src;
            L0:      return LZ;
            default: return (src == LZ) ? LZ : LX;
        endcase
    endfunction

    function automatic logic4_t pmos_eval(input logic4_t gate, input logic4_t src);
        case (gate)
            L0:      return src;
            L1:      return LZ;
            default: return (src == LZ) ? LZ : LX;
        endcase
    endfunction

    function automatic logic4_t resolve2(input logic4_t a, input logic4_t b);
        if (a == LZ)
            return b;
        else if (b == LZ)
            return a;
        else if (a == b)
            return a;
        else
            return LX;
    endfunction

endpackage

// File: rtl/mos_lane.sv
// One NMOS/PMOS pair sharing a drain: device evaluation plus drain resolution.
// Latency: combinational. Backpressure: none.
// Conflict flags only a hard 0-vs-1 fight; X against a driver is not a fight.
module mos_lane
    import mos_pkg::*;
(
    input  logic4_t gate_n,
    input  logic4_t src_n,
    input  logic4_t gate_p,
    input  logic4_t src_p,
    output logic4_t drain,
    output logic    conflict
);

    logic4_t n_out;
    logic4_t p_out;

    always_comb begin
        n_out    = nmos_eval(gate_n, src_n);
        p_out    = pmos_eval(gate_p, src_p);
        drain    = resolve2(n_out, p_out);
        conflict = ((n_out == L0) && (p_out == L1)) ||
                   ((n_out == L1) && (p_out == L0));
    end

endmodule

// File: rtl/mos_switch_pair.sv
// Registered switch-level model of LANES complementary pairs; MOS_CONFLICT_CNT_EN adds a conflict counter.
// Latency: 1 cycle from inputs to drain/conflict. Backpressure: none, evaluates every edge.
// Reset is synchronous active-high and overrides evaluation.
module mos_switch_pair
    import mos_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*LANES-1:0]   gate_n,
    input  logic [2*LANES-1:0]   src_n,
    input  logic [2*LANES-1:0]   gate_p,
    input  logic [2*LANES-1:0]   src_p,
    output logic [2*LANES-1:0]   drain,
    output logic [LANES-1:0]     conflict
`ifdef MOS_CONFLICT_CNT_EN
    ,
    output logic [7:0]           conflict_cnt
`endif
);

    logic [2*LANES-1:0] lane_drain;
    logic [LANES-1:0]   lane_conflict;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mos_lane u_lane (
            .gate_n   (gate_n[2*i+1:2*i]),
            .src_n    (src_n[2*i+1:2*i]),
            .gate_p   (gate_p[2*i+1:2*i]),
            .src_p    (src_p[2*i+1:2*i]),
            .drain    (lane_drain[2*i+1:2*i]),
            .conflict (lane_conflict[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drain    <= {LANES{LZ}};
            conflict <= '0;
        end else begin
            drain    <= lane_drain;
            conflict <= lane_conflict;
        end
    end

`ifdef MOS_CONFLICT_CNT_EN
    // Counts conflicting edges, not conflicting lanes; sticks at 255.
    always_ff @(posedge clk) begin
        if (rst)
            conflict_cnt <= 8'd0;
        else if ((|lane_conflict) && (conflict_cnt != 8'hFF))
            conflict_cnt <= conflict_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_mos_switch_pair.sv
// Directed-vector bench for mos_switch_pair with LANES = 4.
// Counter checks are included only when MOS_CONFLICT_CNT_EN is defined.
module tb_mos_switch_pair;

    logic       clk;
    logic       rst;
    logic [7:0] gate_n;
    logic [7:0] src_n;
    logic [7:0] gate_p;
    logic [7:0] src_p;
    logic [7:0] drain;
    logic [3:0] conflict;
`ifdef MOS_CONFLICT_CNT_EN
    logic [7:0] conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mos_switch_pair #(.LANES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .gate_n   (gate_n),
        .src_n    (src_n),
        .gate_p   (gate_p),
        .src_p    (src_p),
        .drain    (drain),
        .conflict (conflict)
`ifdef MOS_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [7:0] exp);
`ifdef MOS_CONFLICT_CNT_EN
        check(tag, {24'd0, conflict_cnt}, {24'd0, exp});
`else
        if (exp == 8'hFF && tag.len() == 0) $display("unused");
`endif
    endtask

    // Drive one vector set, then sample 1 time unit after the next rising edge.
    task automatic step(input logic [7:0] gn, input logic [7:0] sn,
                        input logic [7:0] gp, input logic [7:0] sp);
        gate_n = gn;
        src_n  = sn;
        gate_p = gp;
        src_p  = sp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        // Reset with a full short on the inputs: reset must win.
        step(8'h55, 8'h00, 8'h00, 8'h55);
        check("reset_drain", {24'd0, drain}, 32'h0000_00AA);
        check("reset_conflict", {28'd0, conflict}, 32'h0);
        check_cnt("reset_cnt", 8'h00);

        rst = 1'b0;
        // Inverter, a = 1 on every lane.
        step(8'h55, 8'h00, 8'h55, 8'h55);
        check("inv_a1_drain", {24'd0, drain}, 32'h0000_0000);
        check("inv_a1_conflict", {28'd0, conflict}, 32'h0);

        // Inverter, a = 0 on every lane.
        step(8'h00, 8'h00, 8'h00, 8'h55);
        check("inv_a0_drain", {24'd0, drain}, 32'h0000_0055);
        check("inv_a0_conflict", {28'd0, conflict}, 32'h0);

        // Both devices off.
        step(8'h00, 8'h00, 8'h55, 8'h55);
        check("cutoff_drain", {24'd0, drain}, 32'h0000_00AA);

        // NMOS gate X/Z with source 0 or Z, PMOS off.
        step(8'hEB, 8'h88, 8'h55, 8'h55);
        check("nmos_xgate_drain", {24'd0, drain}, 32'h0000_00BB);
        check("nmos_xgate_conflict", {28'd0, conflict}, 32'h0);

        // PMOS gate X/Z with source 1 or Z, NMOS off.
        step(8'h00, 8'h00, 8'hAF, 8'h99);
        check("pmos_xgate_drain", {24'd0, drain}, 32'h0000_00BB);

        // Source X/Z propagation, equal drivers, X against a driver.
        step(8'h55, 8'hE3, 8'h01, 8'h51);
        check("xprop_drain", {24'd0, drain}, 32'h0000_00D3);
        check("xprop_conflict", {28'd0, conflict}, 32'h0);
        check_cnt("xprop_cnt", 8'h00);

        // Lane independence: inverter, short, cut-off, cut-off.
        step(8'h05, 8'h00, 8'h51, 8'h55);
        check("indep_drain", {24'd0, drain}, 32'h0000_00AC);
        check("indep_conflict", {28'd0, conflict}, 32'h2);
        check_cnt("indep_cnt", 8'h01);

        // Reverse fight on lane 0: NMOS passes 1, PMOS passes 0.
        step(8'h01, 8'h01, 8'h54, 8'h54);
        check("revfight_drain", {24'd0, drain}, 32'h0000_00AB);
        check("revfight_conflict", {28'd0, conflict}, 32'h1);
        check_cnt("revfight_cnt", 8'h02);

        // No conflict: counter holds.
        step(8'h00, 8'h00, 8'h55, 8'h55);
        check("hold_conflict", {28'd0, conflict}, 32'h0);
        check_cnt("hold_cnt", 8'h02);

        // Short, then reset mid-operation.
        step(8'h55, 8'h00, 8'h00, 8'h55);
        check("short_pre_drain", {24'd0, drain}, 32'h0000_00FF);
        check_cnt("short_pre_cnt", 8'h03);
        rst = 1'b1;
        step(8'h55, 8'h00, 8'h00, 8'h55);
        check("midrst_drain", {24'd0, drain}, 32'h0000_00AA);
        check("midrst_conflict", {28'd0, conflict}, 32'h0);
        check_cnt("midrst_cnt", 8'h00);
        rst = 1'b0;

        // Three shorted edges after release.
        for (int k = 1; k <= 3; k++) begin
            step(8'h55, 8'h00, 8'h00, 8'h55);
            check("short_drain", {24'd0, drain}, 32'h0000_00FF);
            check("short_conflict", {28'd0, conflict}, 32'hF);
            check_cnt("short_cnt", 8'(k));
        end

        // Saturation: 251 more edges reach 254, one more reaches 255, then stick.
        repeat (251) step(8'h55, 8'h00, 8'h00, 8'h55);
        check_cnt("sat_cnt_254", 8'hFE);
        step(8'h55, 8'h00, 8'h00, 8'h55);
        check_cnt("sat_cnt_255", 8'hFF);
        repeat (48) step(8'h55, 8'h00, 8'h00, 8'h55);
        check_cnt("sat_cnt_hold", 8'hFF);

        step(8'h00, 8'h00, 8'h55, 8'h55);
        check("final_drain", {24'd0, drain}, 32'h0000_00AA);
        check("final_conflict", {28'd0, conflict}, 32'h0);
        check_cnt("final_cnt", 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
